pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: bus widths, FSM state encodings and bubble constants.
package pipe_ctrl_pkg;

  localparam int PIPE_ADDR_W = 32;
  localparam int PIPE_REG_AW = 5;
  localparam int PIPE_INSN_W = 32;

  localparam logic [PIPE_ADDR_W-1:0] BUBBLE_ADDR = {PIPE_ADDR_W{1'b0}};
  localparam logic [PIPE_INSN_W-1:0] BUBBLE_WORD = {PIPE_INSN_W{1'b0}};

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: the EX load writes a register the ID instruction reads.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  output logic              lu
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rs1_hit_s = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit_s = id_rs2_used && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu = ex_mem_read && (ex_rd != {REG_AW{1'b0}}) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: PC hold/redirect, IF/ID stall/flush and ID/EX bubbles.
// Optional performance counters are enabled with PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW,
  parameter int ADDR_W = PIPE_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              imem_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  output logic              pc_hold,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              if_id_stall,
  output logic              if_id_flush,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              id_ex_flush
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] redirect_r;
  logic [ADDR_W-1:0] redirect_nxt_s;
  logic              stall_r;
  logic              stall_s;
  logic              redir_flush_s;
  logic              lu_s;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .lu          (lu_s)
  );

  // State, redirect target and one-shot stall flag
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      redirect_r <= {ADDR_W{1'b0}};
      stall_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      redirect_r <= redirect_nxt_s;
      stall_r    <= stall_s;
    end
  end

  // Next state and control outputs; stall_r limits a load-use stall to one cycle
  always_comb begin
    state_nxt_s    = state_r;
    redirect_nxt_s = redirect_r;
    stall_s        = 1'b0;
    redir_flush_s  = 1'b0;
    pc_hold        = 1'b0;
    pc_load        = 1'b0;
    pc_target      = BUBBLE_ADDR[ADDR_W-1:0];
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    if (rst) begin
      pc_hold     = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_r)
        ST_BOOT: begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          if (ex_br_taken) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            redir_flush_s = 1'b1;
            if (imem_valid) begin
              pc_load   = 1'b1;
              pc_target = ex_br_target;
            end else begin
              pc_hold        = 1'b1;
              redirect_nxt_s = ex_br_target;
              state_nxt_s    = ST_REDIRECT;
            end
          end else if (lu_s && !stall_r) begin
            pc_hold     = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            stall_s     = 1'b1;
          end else if (!imem_valid) begin
            pc_hold     = 1'b1;
            if_id_flush = 1'b1;
            state_nxt_s = ST_WAIT_MEM;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_WAIT_MEM: begin
          if (ex_br_taken) begin
            pc_hold        = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redir_flush_s  = 1'b1;
            redirect_nxt_s = ex_br_target;
            state_nxt_s    = ST_REDIRECT;
          end else if (imem_valid) begin
            state_nxt_s = ST_RUN;
          end else begin
            pc_hold     = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        ST_REDIRECT: begin
          // The fetch returning now is wrong-path: drop it and load the saved target
          pc_target     = redirect_r;
          if_id_flush   = 1'b1;
          redir_flush_s = 1'b1;
          if (imem_valid) begin
            pc_load     = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            pc_hold = 1'b1;
          end
        end
        default: begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt_s = ST_BOOT;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating stall and redirect-flush counters
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (redir_flush_s && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule
